// File: rtl/mnist_frame_streamer_if.sv
// Byte-source, classifier-stream and result-capture signals of the MNIST frame streamer.
// master = the surrounding board logic / bench, slave = the streamer itself.
interface mnist_frame_streamer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_err;
  logic       stream_en;
  logic [7:0] stream_data;
  logic [4:0] stream_idx;
  logic       frame_start;
  logic [3:0] res_idx_in;
  logic [7:0] res_val_in;
  logic [3:0] res_idx;
  logic [7:0] res_val;
  logic       res_valid;

  modport master (
    output wr_valid, wr_data, wr_last, stream_en, res_idx_in, res_val_in,
    input  wr_ready, wr_err, stream_data, stream_idx, frame_start, res_idx, res_val, res_valid
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, stream_en, res_idx_in, res_val_in,
    output wr_ready, wr_err, stream_data, stream_idx, frame_start, res_idx, res_val, res_valid
  );
endinterface

// File: rtl/mnist_frame_streamer.sv
// Double-buffered 16x16 1-bit image feeder for the LGN MNIST classifier: fills one bank from a
// byte source while the other bank streams continuously, and latches the classifier result.
module mnist_frame_streamer #(
  parameter int FRAME_BYTES   = 32,
  parameter int CAPTURE_PHASE = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  mnist_frame_streamer_if.slave bus
);
  localparam int PTR_W = $clog2(FRAME_BYTES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_BYTES - 1);
  localparam logic [PTR_W-1:0] CAP_IDX  = PTR_W'(CAPTURE_PHASE);

  typedef enum logic {FILL, PENDING} wstate_t;

  wstate_t          wstate;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic             disp_bank;
  logic             disp_bank_next;
  logic             have_frame;
  logic             have_frame_next;
  logic             accept;
  logic             swap;
  logic             capture;
  logic             wr_ready_q;
  logic             wr_err_q;
  logic [7:0]       stream_data_q;
  logic             frame_start_q;
  logic [3:0]       res_idx_q;
  logic [7:0]       res_val_q;
  logic             res_valid_q;

  logic [7:0] bank_mem [2][FRAME_BYTES];

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    accept          = bus.wr_valid && (wstate == FILL);
    swap            = bus.stream_en && (rd_ptr == LAST_IDX) && (wstate == PENDING);
    capture         = bus.stream_en && have_frame && (rd_ptr == CAP_IDX);
    rd_ptr_next     = bus.stream_en ? rd_ptr + 1'b1 : rd_ptr;
    disp_bank_next  = swap ? ~disp_bank : disp_bank;
    have_frame_next = have_frame | swap;
  end

  // NOTE: the image banks carry no reset; have_frame gates their output until a full frame lands.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      bank_mem[~disp_bank][wr_ptr] <= bus.wr_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate        <= FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      disp_bank     <= 1'b0;
      have_frame    <= 1'b0;
      wr_ready_q    <= 1'b1;
      wr_err_q      <= 1'b0;
      stream_data_q <= 8'h00;
      frame_start_q <= 1'b0;
      res_idx_q     <= 4'h0;
      res_val_q     <= 8'h00;
      res_valid_q   <= 1'b0;
    end else begin
      wr_err_q    <= 1'b0;
      res_valid_q <= capture;
      disp_bank   <= disp_bank_next;
      have_frame  <= have_frame_next;

      if (capture) begin
        res_idx_q <= bus.res_idx_in;
        res_val_q <= bus.res_val_in;
      end

      // The swap edge already presents byte 0 of the new bank.
      if (bus.stream_en) begin
        rd_ptr        <= rd_ptr_next;
        stream_data_q <= have_frame_next ? bank_mem[disp_bank_next][rd_ptr_next] : 8'h00;
        frame_start_q <= have_frame_next && (rd_ptr_next == '0);
      end

      case (wstate)
        FILL: begin
          if (accept) begin
            if (wr_ptr == LAST_IDX) begin
              wstate     <= PENDING;
              wr_ready_q <= 1'b0;
              wr_ptr     <= '0;
            end else if (bus.wr_last) begin
              wr_ptr   <= '0;
              wr_err_q <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        PENDING: begin
          if (swap) begin
            wstate     <= FILL;
            wr_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.wr_ready    = wr_ready_q;
  assign bus.wr_err      = wr_err_q;
  assign bus.stream_data = stream_data_q;
  assign bus.stream_idx  = rd_ptr;
  assign bus.frame_start = frame_start_q;
  assign bus.res_idx     = res_idx_q;
  assign bus.res_val     = res_val_q;
  assign bus.res_valid   = res_valid_q;
endmodule

// File: tb/tb_mnist_frame_streamer.sv
// Randomised bench for mnist_frame_streamer: a frame-level model (queues and arrays) predicts
// every output each cycle; a few literal expectations pin the model to the intended behaviour.
module tb_mnist_frame_streamer;
  localparam int CAP = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mnist_frame_streamer_if bus ();

  mnist_frame_streamer #(.FRAME_BYTES(32), .CAPTURE_PHASE(CAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Frame-level model: completed frames move whole from the fill queue to pending to display.
  bit              m_valid = 1'b0;
  int              m_rd;
  bit              m_have, m_pending, m_err, m_rv, m_fs;
  byte unsigned    m_disp [32];
  byte unsigned    m_pend [32];
  byte unsigned    m_fill [$];
  logic [7:0]      m_sd;
  logic [3:0]      m_ri;
  logic [7:0]      m_rval;

  always @(posedge clk) begin
    bit acc, swp, cap;
    if (!rst_n) begin
      m_rd = 0; m_have = 0; m_pending = 0; m_err = 0; m_rv = 0; m_fs = 0;
      m_sd = 8'h00; m_ri = 4'h0; m_rval = 8'h00;
      m_fill.delete();
      m_valid = 1'b1;
    end else begin
      acc = bus.wr_valid && !m_pending;
      swp = bus.stream_en && (m_rd == 31) && m_pending;
      cap = bus.stream_en && m_have && (m_rd == CAP);
      m_err = 0;
      m_rv  = cap;
      if (cap) begin
        m_ri   = bus.res_idx_in;
        m_rval = bus.res_val_in;
      end
      if (swp) begin
        m_disp    = m_pend;
        m_have    = 1;
        m_pending = 0;
      end
      if (bus.stream_en) begin
        m_rd = (m_rd + 1) % 32;
        m_sd = m_have ? m_disp[m_rd] : 8'h00;
        m_fs = m_have && (m_rd == 0);
      end
      if (acc) begin
        m_fill.push_back(bus.wr_data);
        if (m_fill.size() == 32) begin
          for (int i = 0; i < 32; i++) m_pend[i] = m_fill[i];
          m_pending = 1;
          m_fill.delete();
        end else if (bus.wr_last) begin
          m_err = 1;
          m_fill.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("wr_ready",    bus.wr_ready,    !m_pending);
      check("wr_err",      bus.wr_err,      m_err);
      check("stream_data", bus.stream_data, m_sd);
      check("stream_idx",  bus.stream_idx,  m_rd);
      check("frame_start", bus.frame_start, m_fs);
      check("res_idx",     bus.res_idx,     m_ri);
      check("res_val",     bus.res_val,     m_rval);
      check("res_valid",   bus.res_valid,   m_rv);
    end
  end

  // stream_en driver: 0 = held low, 1 = held high, 2 = random (~75% high)
  int en_mode = 1;
  always @(negedge clk) begin
    case (en_mode)
      0:       bus.stream_en = 1'b0;
      1:       bus.stream_en = 1'b1;
      default: bus.stream_en = ($urandom % 4) != 0;
    endcase
  end

  int err_cnt = 0;
  int rv_cnt  = 0;
  always @(negedge clk) begin
    if (rst_n && bus.wr_err === 1'b1) err_cnt++;
    if (rst_n && bus.res_valid === 1'b1) rv_cnt++;
  end

  task automatic send(input logic [7:0] d, input bit last);
    int n = 0;
    @(negedge clk);
    while (bus.wr_ready !== 1'b1 && n < 3000) begin
      bus.wr_valid = 1'b0;
      n++;
      @(negedge clk);
    end
    if (n >= 3000) bound_expired("send_wait_ready");
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    @(negedge clk);
    while (bus.stream_idx !== 5'(k) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) bound_expired("wait_idx");
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.wr_ready !== 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) bound_expired("wait_ready");
  endtask

  initial begin
    int n;
    int len;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'h00;
    bus.wr_last    = 1'b0;
    bus.res_idx_in = 4'h0;
    bus.res_val_in = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // No frame yet: zeros stream out, source may write, nothing is captured.
    rv_cnt = 0;
    repeat (64) begin
      @(negedge clk);
      check("t1_zero_data", bus.stream_data, 8'h00);
      check("t1_ready",     bus.wr_ready,    1'b1);
    end
    check("t1_no_res_valid", rv_cnt, 0);

    // Ramp frame 0x00..0x1F, then look at it on the stream.
    for (int i = 0; i < 32; i++) send(8'(i), i == 31);
    idle();
    check("t2_ready_low", bus.wr_ready, 1'b0);
    repeat (40) @(negedge clk);
    wait_idx(5);
    check("t2_byte5",  bus.stream_data, 8'h05);
    check("t2_fs_low", bus.frame_start, 1'b0);
    wait_idx(0);
    check("t2_byte0",   bus.stream_data, 8'h00);
    check("t2_fs_high", bus.frame_start, 1'b1);

    // Result capture at phase 1, then freeze with stream_en low.
    bus.res_idx_in = 4'd7;
    bus.res_val_in = 8'h80;
    wait_idx(2);
    check("t5_res_idx",   bus.res_idx,   4'd7);
    check("t5_res_val",   bus.res_val,   8'h80);
    check("t5_res_valid", bus.res_valid, 1'b1);
    en_mode = 0;
    @(negedge clk);
    rv_cnt = 0;
    repeat (40) @(negedge clk);
    check("t5_frozen_no_pulse", rv_cnt, 0);
    en_mode = 1;

    // Frame A (0xAA) displayed, then frame B (0x55) written during streaming.
    for (int i = 0; i < 32; i++) send(8'hAA, i == 31);
    idle();
    wait_ready();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 32; i++) send(8'h55, i == 31);
    idle();
    n = 0;
    while (bus.stream_data !== 8'h55 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) bound_expired("t3_wait_55");
    else check("t3_first55_idx0", bus.stream_idx, 5'd0);

    // Aborted frame: wr_last on byte 9, then a complete frame.
    err_cnt = 0;
    for (int i = 0; i < 10; i++) send(8'hE0 + 8'(i), i == 9);
    idle();
    repeat (3) @(negedge clk);
    check("t4_err_pulses", err_cnt, 1);
    for (int i = 0; i < 32; i++) send(8'(i * 7 + 3), i == 31);
    idle();
    repeat (70) @(negedge clk);

    // Random frames, aborts, gaps, stream stalls and result inputs.
    en_mode = 2;
    for (int f = 0; f < 30; f++) begin
      len = ($urandom % 5 == 0) ? int'($urandom_range(1, 31)) : 32;
      bus.res_idx_in = 4'($urandom);
      bus.res_val_in = 8'($urandom);
      for (int i = 0; i < len; i++) begin
        if ($urandom % 4 == 0) idle();
        send(8'($urandom), (i == len - 1) && ((len < 32) || ($urandom % 2 == 1)));
      end
      idle();
    end
    repeat (100) @(negedge clk);

    // Reset while a completed frame is pending; it must never reach the stream.
    en_mode = 1;
    wait_ready();
    en_mode = 0;
    for (int i = 0; i < 32; i++) send(8'hC3, i == 31);
    idle();
    check("t6_pending", bus.wr_ready, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rst_data",  bus.stream_data, 8'h00);
    check("t6_rst_idx",   bus.stream_idx,  5'd0);
    check("t6_rst_ready", bus.wr_ready,    1'b1);
    check("t6_rst_res",   bus.res_val,     8'h00);
    en_mode = 1;
    repeat (64) begin
      @(negedge clk);
      check("t6_zero_data", bus.stream_data, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
